spi_frame_tx_ctrl: RTL and testbench

Sequences the image FIFO-to-SPI path. Frames each camera image into an SPI byte stream: 4-byte header, payload bytes drained from the image FIFO, 5-byte trailer carrying the payload byte count. Sits between the single-clock image FIFO read side and spi_master, all in the 80 MHz domain. Replaces the free-running FIFO read loop so the receiver can find frame boundaries.

---
 rtl/spi_frame_tx_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_frame_tx_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx_ctrl.sv
// Frames camera image bytes for spi_master: 4-byte header, FIFO payload, 5-byte trailer with payload count.
// One SPI byte in flight at a time; vsync boundaries close the running frame once the FIFO drains.
module spi_frame_tx_ctrl #(
   parameter logic [7:0] SYNC0     = 8'hA5,
   parameter logic [7:0] SYNC1     = 8'h5A,
   parameter logic [7:0] EOF0      = 8'hC3,
   parameter logic [7:0] EOF1      = 8'h3C,
   parameter int         CNT_W     = 24,
   parameter logic       VSYNC_POL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_enable,
   input  logic       cam_vsync_in,
   input  logic       fifo_is_empty,
   input  logic [7:0] fifo_dataout,
   output logic       fifo_read_en,
   input  logic       spi_tx_done,
   output logic       spi_tx_en,
   output logic [7:0] spi_data_in,
   output logic       frame_active,
   output logic [7:0] frame_id,
   output logic       frame_overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_PAY_RD, S_PAY_LAT, S_PAY_WAIT, S_TRL
   } state_t;

   state_t state_q, state_d;

   logic             vs_meta_q, vs_meta_d;
   logic             vs_sync_q, vs_sync_d;
   logic             vs_prev_q, vs_prev_d;
   logic [2:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             end_pend_q, end_pend_d;
   logic             start_pend_q, start_pend_d;
   logic             spi_tx_en_q, spi_tx_en_d;
   logic [7:0]       spi_data_q, spi_data_d;
   logic             frame_active_q, frame_active_d;
   logic [7:0]       frame_id_q, frame_id_d;
   logic             frame_overrun_q, frame_overrun_d;

   logic boundary;
   logic byte_done;
   logic hdr_last;
   logic trl_last;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [7:0] id);
      case (i)
         3'd0:    return SYNC0;
         3'd1:    return SYNC1;
         3'd2:    return id;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] trl_byte(input logic [2:0] i, input logic [CNT_W-1:0] c);
      logic [23:0] c24;
      c24 = 24'(c);
      case (i)
         3'd0:    return EOF0;
         3'd1:    return EOF1;
         3'd2:    return c24[23:16];
         3'd3:    return c24[15:8];
         default: return c24[7:0];
      endcase
   endfunction

   // Boundary is the first synchronized sample at the active level
   always_comb begin : sync_comb
      vs_meta_d = cam_vsync_in;
      vs_sync_d = vs_meta_q;
      vs_prev_d = vs_sync_q;
   end

   assign boundary  = (vs_sync_q == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
   assign byte_done = busy_q && spi_tx_done;
   assign hdr_last  = (state_q == S_HDR) && byte_done && (idx_q == 3'd3);
   assign trl_last  = (state_q == S_TRL) && byte_done && (idx_q == 3'd4);

   always_ff @(posedge clk) begin : state_reg
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (boundary && tx_enable) state_d = S_HDR;
         S_HDR:      if (hdr_last) state_d = S_PAY_RD;
         S_PAY_RD: begin
            if (!fifo_is_empty)  state_d = S_PAY_LAT;
            else if (end_pend_q) state_d = S_TRL;
         end
         S_PAY_LAT:  state_d = S_PAY_WAIT;
         S_PAY_WAIT: if (spi_tx_done) state_d = S_PAY_RD;
         S_TRL: begin
            if (trl_last)
               state_d = ((start_pend_q || boundary) && tx_enable) ? S_HDR : S_IDLE;
         end
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin : out_comb
      idx_d           = idx_q;
      busy_d          = busy_q;
      cnt_d           = cnt_q;
      end_pend_d      = end_pend_q;
      start_pend_d    = start_pend_q;
      spi_tx_en_d     = 1'b0;
      spi_data_d      = spi_data_q;
      frame_active_d  = frame_active_q;
      frame_id_d      = frame_id_q;
      frame_overrun_d = 1'b0;

      // In header/payload both flags move together; in trailer only the next start is pending
      if (boundary) begin
         case (state_q)
            S_HDR, S_PAY_RD, S_PAY_LAT, S_PAY_WAIT: begin
               if (end_pend_q) begin
                  frame_overrun_d = 1'b1;
               end else begin
                  end_pend_d   = 1'b1;
                  start_pend_d = 1'b1;
               end
            end
            S_TRL: begin
               if (start_pend_q) frame_overrun_d = 1'b1;
               else              start_pend_d    = 1'b1;
            end
            default: ;
         endcase
      end

      case (state_q)
         S_HDR: begin
            frame_active_d = 1'b1;
            cnt_d          = '0;
            if (!busy_q) begin
               spi_tx_en_d = 1'b1;
               spi_data_d  = hdr_byte(idx_q, frame_id_q);
               busy_d      = 1'b1;
            end else if (spi_tx_done) begin
               busy_d = 1'b0;
               idx_d  = hdr_last ? 3'd0 : idx_q + 3'd1;
            end
         end
         S_PAY_LAT: begin
            spi_data_d  = fifo_dataout;
            spi_tx_en_d = 1'b1;
         end
         S_PAY_WAIT: begin
            if (spi_tx_done) cnt_d = sat_inc(cnt_q);
         end
         S_TRL: begin
            if (!busy_q) begin
               spi_tx_en_d = 1'b1;
               spi_data_d  = trl_byte(idx_q, cnt_q);
               busy_d      = 1'b1;
            end else if (spi_tx_done) begin
               busy_d = 1'b0;
               idx_d  = trl_last ? 3'd0 : idx_q + 3'd1;
            end
            if (trl_last) begin
               frame_active_d = 1'b0;
               frame_id_d     = frame_id_q + 8'd1;
               end_pend_d     = 1'b0;
               start_pend_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin : ctrl_regs
      if (rst) begin
         vs_meta_q       <= ~VSYNC_POL;
         vs_sync_q       <= ~VSYNC_POL;
         vs_prev_q       <= ~VSYNC_POL;
         idx_q           <= 3'd0;
         busy_q          <= 1'b0;
         cnt_q           <= '0;
         end_pend_q      <= 1'b0;
         start_pend_q    <= 1'b0;
         spi_tx_en_q     <= 1'b0;
         spi_data_q      <= 8'h00;
         frame_active_q  <= 1'b0;
         frame_id_q      <= 8'h00;
         frame_overrun_q <= 1'b0;
      end else begin
         vs_meta_q       <= vs_meta_d;
         vs_sync_q       <= vs_sync_d;
         vs_prev_q       <= vs_prev_d;
         idx_q           <= idx_d;
         busy_q          <= busy_d;
         cnt_q           <= cnt_d;
         end_pend_q      <= end_pend_d;
         start_pend_q    <= start_pend_d;
         spi_tx_en_q     <= spi_tx_en_d;
         spi_data_q      <= spi_data_d;
         frame_active_q  <= frame_active_d;
         frame_id_q      <= frame_id_d;
         frame_overrun_q <= frame_overrun_d;
      end
   end

   assign fifo_read_en  = !rst && (state_q == S_PAY_RD) && !fifo_is_empty;
   assign spi_tx_en     = spi_tx_en_q;
   assign spi_data_in   = spi_data_q;
   assign frame_active  = frame_active_q;
   assign frame_id      = frame_id_q;
   assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_spi_frame_tx_ctrl.sv
// Bench for spi_frame_tx_ctrl: FIFO and spi_master responders, frame-level byte-stream model,
// directed scenario sequence with random payload and random SPI byte times.
module tb_spi_frame_tx_ctrl;

   logic       clk          = 1'b0;
   logic       rst          = 1'b1;
   logic       tx_enable    = 1'b0;
   logic       cam_vsync_in = 1'b0;
   logic       fifo_is_empty;
   logic [7:0] fifo_dataout = 8'h00;
   logic       fifo_read_en;
   logic       spi_tx_done  = 1'b0;
   logic       spi_tx_en;
   logic [7:0] spi_data_in;
   logic       frame_active;
   logic [7:0] frame_id;
   logic       frame_overrun;

   always #5 clk = ~clk;

   spi_frame_tx_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .tx_enable     (tx_enable),
      .cam_vsync_in  (cam_vsync_in),
      .fifo_is_empty (fifo_is_empty),
      .fifo_dataout  (fifo_dataout),
      .fifo_read_en  (fifo_read_en),
      .spi_tx_done   (spi_tx_done),
      .spi_tx_en     (spi_tx_en),
      .spi_data_in   (spi_data_in),
      .frame_active  (frame_active),
      .frame_id      (frame_id),
      .frame_overrun (frame_overrun)
   );

   int n_chk = 0;
   int n_err = 0;

   // Image FIFO: data appears one cycle after the read strobe
   logic [7:0] mem [0:1023];
   int         push_cnt     = 0;
   int         pop_cnt      = 0;
   logic       rd_empty_err = 1'b0;

   assign fifo_is_empty = (push_cnt == pop_cnt);

   always @(posedge clk) begin
      if (fifo_read_en) begin
         if (push_cnt == pop_cnt) rd_empty_err <= 1'b1;
         fifo_dataout <= mem[pop_cnt[9:0]];
         pop_cnt      <= pop_cnt + 1;
      end
   end

   // spi_master: random byte time, flags overlapping starts or unstable data
   logic [7:0] cap_q [$];
   logic       spi_busy = 1'b0;
   int         spi_cnt  = 0;
   logic [7:0] spi_hold = 8'h00;
   logic       spi_err  = 1'b0;
   int         ovr_cnt  = 0;

   always @(posedge clk) begin
      if (frame_overrun) ovr_cnt <= ovr_cnt + 1;
      if (rst) begin
         spi_busy    <= 1'b0;
         spi_tx_done <= 1'b0;
      end else if (spi_busy) begin
         if (spi_tx_en || (spi_data_in !== spi_hold)) spi_err <= 1'b1;
         if (spi_tx_done) begin
            spi_tx_done <= 1'b0;
            spi_busy    <= 1'b0;
         end else if (spi_cnt <= 1) begin
            spi_tx_done <= 1'b1;
         end else begin
            spi_cnt <= spi_cnt - 1;
         end
      end else if (spi_tx_en) begin
         spi_busy <= 1'b1;
         spi_hold <= spi_data_in;
         cap_q.push_back(spi_data_in);
         spi_cnt  <= int'($urandom_range(5, 1));
      end
   end

   // Frame-level reference: expected SPI byte stream
   logic [7:0] exp_q [$];
   logic [7:0] pay_q [$];
   bit         m_open  = 1'b0;
   int         m_id    = 0;
   int         chk_idx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      mem[push_cnt[9:0]] = b;
      push_cnt++;
      pay_q.push_back(b);
   endtask

   task automatic vsync_pulse();
      @(negedge clk);
      cam_vsync_in = 1'b1;
      tick(8);
      cam_vsync_in = 1'b0;
      tick(8);
   endtask

   task automatic model_boundary();
      int n;
      if (m_open) begin
         n = pay_q.size();
         while (pay_q.size() > 0) exp_q.push_back(pay_q.pop_front());
         exp_q.push_back(8'hC3);
         exp_q.push_back(8'h3C);
         exp_q.push_back(8'(n >> 16));
         exp_q.push_back(8'(n >> 8));
         exp_q.push_back(8'(n));
         m_id   = (m_id + 1) % 256;
         m_open = 1'b0;
      end
      if (tx_enable) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'h5A);
         exp_q.push_back(8'(m_id));
         exp_q.push_back(8'h00);
         m_open = 1'b1;
      end
   endtask

   task automatic check_stream(input string tag);
      int budget;
      budget = 0;
      while (cap_q.size() < exp_q.size() && budget < 6000) begin
         @(negedge clk);
         budget++;
      end
      chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = chk_idx; i < exp_q.size(); i++)
         if (i < cap_q.size()) chk(tag, 32'(cap_q[i]), 32'(exp_q[i]));
      chk_idx = exp_q.size();
   endtask

   task automatic wait_drain();
      int b;
      b = 0;
      while (pop_cnt != push_cnt && b < 5000) begin
         @(negedge clk);
         b++;
      end
      chk("drain", 32'(pop_cnt), 32'(push_cnt));
   endtask

   task automatic chk_idle(input string tag, input logic [7:0] id);
      chk(tag, {12'h0, spi_tx_en, fifo_read_en, frame_active, frame_overrun, spi_data_in, frame_id},
          {12'h0, 4'b0000, 8'h00, id});
   endtask

   initial begin
      int ovr_base;
      int left;
      int b;

      // reset and disabled boundaries
      rst = 1'b1;
      tick(2);
      chk_idle("reset", 8'h00);
      rst = 1'b0;
      vsync_pulse();
      vsync_pulse();
      model_boundary();
      tick(20);
      chk("no_tx_disabled", 32'(cap_q.size()), 32'd0);

      // basic frame with preloaded bytes, then the next header
      tx_enable = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      vsync_pulse();
      model_boundary();
      wait_drain();
      tick(40);
      vsync_pulse();
      model_boundary();
      check_stream("basic");
      chk("active_mid", 32'(frame_active), 32'd1);
      chk("id_mid", 32'(frame_id), 32'd1);

      // FIFO-empty stall: sparse writes
      for (int i = 0; i < 10; i++) begin
         push(8'($urandom));
         tick(50);
      end
      wait_drain();
      tick(40);
      vsync_pulse();
      model_boundary();
      check_stream("stall");
      chk("rd_when_empty", 32'(rd_empty_err), 32'd0);
      chk("spi_protocol", 32'(spi_err), 32'd0);

      // late data: boundary with bytes still queued
      for (int i = 0; i < 4; i++) push(8'($urandom));
      vsync_pulse();
      model_boundary();
      check_stream("late");

      // overrun: two boundaries during one payload
      ovr_base = ovr_cnt;
      for (int i = 0; i < 20; i++) push(8'($urandom));
      vsync_pulse();
      vsync_pulse();
      model_boundary();
      check_stream("ovr");
      chk("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
      tick(200);
      chk("one_hdr", 32'(cap_q.size()), 32'(exp_q.size()));

      // tx_enable dropped mid-frame: trailer, then idle
      push(8'($urandom));
      push(8'($urandom));
      tx_enable = 1'b0;
      vsync_pulse();
      model_boundary();
      check_stream("txoff");
      tick(30);
      chk("active_off", 32'(frame_active), 32'd0);
      chk("id_after", 32'(frame_id), 32'(m_id));
      chk("idle_quiet", 32'(cap_q.size()), 32'(exp_q.size()));

      // reset during a payload byte
      tx_enable = 1'b1;
      for (int i = 0; i < 30; i++) push(8'($urandom));
      vsync_pulse();
      model_boundary();
      while (pay_q.size() > 0) exp_q.push_back(pay_q.pop_front());
      b = 0;
      while (cap_q.size() < chk_idx + 7 && b < 3000) begin
         @(negedge clk);
         b++;
      end
      b = 0;
      while (!spi_tx_en && b < 500) begin
         @(negedge clk);
         b++;
      end
      chk("pay_tx_seen", 32'(spi_tx_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("rst_mid", 8'h00);
      rst = 1'b0;
      tick(20);
      left = push_cnt - pop_cnt;
      chk("abort_len", 32'(exp_q.size() - cap_q.size()), 32'(left));
      while (exp_q.size() > cap_q.size()) pay_q.push_front(exp_q.pop_back());
      check_stream("abort");
      m_open = 1'b0;
      m_id   = 0;
      tick(50);
      chk("no_trailer", 32'(cap_q.size()), 32'(exp_q.size()));

      // next boundary restarts at frame id 0 and drains the leftovers
      vsync_pulse();
      model_boundary();
      tx_enable = 1'b0;
      wait_drain();
      tick(40);
      vsync_pulse();
      model_boundary();
      check_stream("post_rst");
      tick(30);
      chk("final_id", 32'(frame_id), 32'd1);
      chk("final_active", 32'(frame_active), 32'd0);
      chk("final_ovr", 32'(ovr_cnt), 32'd1);
      chk("final_rd_empty", 32'(rd_empty_err), 32'd0);
      chk("final_spi_protocol", 32'(spi_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
